// File: rtl/uart_pkg.sv
// Shared definitions for the UART client-side blocks.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int ERR_COUNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE
    } echo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. The pointers carry one
// extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_echo.sv
// Loopback responder: buffers every received byte and replays it to the
// transmitter through the send_request / tx_busy / tx_done handshake.
module uart_echo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int FIFO_DEPTH   = 16,
    parameter bit DROP_ERRORED = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [DATA_BITS-1:0]        rx_data,
    input  logic                        data_ready,
    input  logic                        parity_err,
    input  logic                        frame_err,
    output logic                        send_request,
    output logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_busy,
    input  logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic [ERR_COUNT_W-1:0]      err_count
);

    echo_state_t              r_state;
    echo_state_t              w_state_next;
    logic                     r_data_ready_q;
    logic                     r_send_request;
    logic                     w_req_next;
    logic [DATA_BITS-1:0]     r_tx_data;
    logic                     r_overflow;
    logic [ERR_COUNT_W-1:0]   r_err_count;

    logic                     w_rx_edge;
    logic                     w_accept;
    logic                     w_err;
    logic                     w_want_push;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [DATA_BITS-1:0]     w_fifo_dout;

    assign w_rx_edge   = data_ready & ~r_data_ready_q;
    assign w_accept    = w_rx_edge & enable;
    assign w_err       = parity_err | frame_err;
    assign w_want_push = w_accept & ~(DROP_ERRORED & w_err);
    assign w_push      = w_want_push & (~w_full | w_pop);

    assign send_request = r_send_request;
    assign tx_data      = r_tx_data;
    assign overflow     = r_overflow;
    assign err_count    = r_err_count;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (rx_data),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // Receive side: edge detect, saturating error count, overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_ready_q <= 1'b0;
            r_err_count    <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_data_ready_q <= data_ready;
            r_overflow     <= w_want_push & w_full & ~w_pop;
            if (w_accept && w_err && (r_err_count != '1))
                r_err_count <= r_err_count + ERR_COUNT_W'(1);
        end
    end

    // Transmit FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_send_request <= 1'b0;
            r_tx_data      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_send_request <= w_req_next;
            if (w_pop) r_tx_data <= w_fifo_dout;
        end
    end

    // Transmit FSM next-state, pop strobe and next request level.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_req_next   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_req_next   = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (tx_busy) w_state_next = WAIT_DONE;
                else         w_req_next   = 1'b1;
            end
            WAIT_DONE: begin
                if (tx_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_echo.sv
// Self-checking bench for uart_echo: directed scenarios plus a randomized
// stream compared against a queue-based reference model.
module tb_uart_echo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          enable     = 1'b1;
    logic [DW-1:0] rx_data    = '0;
    logic          data_ready = 1'b0;
    logic          parity_err = 1'b0;
    logic          frame_err  = 1'b0;
    logic          tx_busy    = 1'b0;
    logic          tx_done    = 1'b0;
    logic          send_request;
    logic [DW-1:0] tx_data;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [7:0]    err_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_cnt  = 0;
    int   ovf_cnt  = 0;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    uart_echo #(
        .DATA_BITS    (DW),
        .FIFO_DEPTH   (DEPTH),
        .DROP_ERRORED (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .send_request (send_request),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .err_count    (err_count)
    );

    // Count request rising edges and overflow-high cycles.
    always @(negedge clk) begin
        if (send_request && !prev_req) req_cnt++;
        prev_req = send_request;
        if (overflow) ovf_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic fe, input int high);
        rx_data    = b;
        parity_err = pe;
        frame_err  = fe;
        data_ready = 1'b1;
        repeat (high) @(negedge clk);
        data_ready = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_req();
        int t = 0;
        while (!send_request && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("req_seen", 32'(send_request), 32'd1);
    endtask

    // Plays the uart transmitter for one request.
    task automatic serve(input int dly, input int blen, output logic [7:0] got);
        wait_req();
        got = tx_data;
        repeat (dly) begin
            @(negedge clk);
            check_eq("req_hold", 32'(send_request), 32'd1);
            check_eq("data_hold_req", 32'(tx_data), 32'(got));
        end
        tx_busy = 1'b1;
        @(negedge clk);
        check_eq("req_drop", 32'(send_request), 32'd0);
        repeat (blen) begin
            @(negedge clk);
            check_eq("data_hold_wait", 32'(tx_data), 32'(got));
        end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    logic [7:0] got;
    logic [7:0] exp_q[$];
    int         base_req;
    int         base_ovf;
    int         m_err;
    int         got_n;
    bit         rx_done;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_req", 32'(send_request), 32'd0);
        check_eq("rst_txdata", 32'(tx_data), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte latency and handshake
        base_req = req_cnt;
        rx_data = 8'h55;
        data_ready = 1'b1;
        @(negedge clk);
        check_eq("lat_level1", 32'(fifo_level), 32'd1);
        check_eq("lat_noreq", 32'(send_request), 32'd0);
        data_ready = 1'b0;
        @(negedge clk);
        check_eq("lat_req", 32'(send_request), 32'd1);
        check_eq("lat_txdata", 32'(tx_data), 32'h55);
        check_eq("lat_level0", 32'(fifo_level), 32'd0);
        serve(3, 20, got);
        check_eq("t1_byte", 32'(got), 32'h55);
        repeat (5) @(negedge clk);
        #1;
        check_eq("t1_reqs", 32'(req_cnt - base_req), 32'd1);
        check_eq("t1_level", 32'(fifo_level), 32'd0);

        // Fill to full with transmitter stalled, overflow, then push+pop when full
        send_byte(8'h00, 1'b0, 1'b0, 1);
        wait_req();
        check_eq("prime_byte", 32'(tx_data), 32'h00);
        tx_busy = 1'b1;
        @(negedge clk);
        check_eq("prime_drop", 32'(send_request), 32'd0);
        base_ovf = ovf_cnt;
        for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0, 1'b0, 1);
        check_eq("full_level", 32'(fifo_level), 32'd16);
        #1;
        check_eq("full_noovf", 32'(ovf_cnt - base_ovf), 32'd0);
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        @(negedge clk);
        #1;
        check_eq("ovf_once", 32'(ovf_cnt - base_ovf), 32'd1);
        check_eq("ovf_level", 32'(fifo_level), 32'd16);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        rx_data = 8'hBB;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check_eq("fullpp_level", 32'(fifo_level), 32'd16);
        check_eq("fullpp_head", 32'(tx_data), 32'h01);
        #1;
        check_eq("fullpp_noovf", 32'(ovf_cnt - base_ovf), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            serve(0, 1, got);
            check_eq("drain_order", 32'(got), 32'(i));
        end
        serve(0, 1, got);
        check_eq("drain_last", 32'(got), 32'hBB);
        check_eq("drain_level", 32'(fifo_level), 32'd0);

        // Errored bytes are dropped and counted, count saturates
        base_req = req_cnt;
        send_byte(8'hA5, 1'b1, 1'b0, 1);
        repeat (3) @(negedge clk);
        check_eq("err_one", 32'(err_count), 32'd1);
        check_eq("err_level", 32'(fifo_level), 32'd0);
        check_eq("err_noreq", 32'(send_request), 32'd0);
        for (int i = 0; i < 299; i++)
            send_byte(8'hA5, (i % 2 == 0), (i % 2 != 0), 1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("err_sat", 32'(err_count), 32'hFF);
        check_eq("err_reqs", 32'(req_cnt - base_req), 32'd0);

        // Long data_ready level yields exactly one byte
        base_req = req_cnt;
        send_byte(8'h3C, 1'b0, 1'b0, 50);
        check_eq("hold_level", 32'(fifo_level), 32'd0);
        #1;
        check_eq("hold_req1", 32'(req_cnt - base_req), 32'd1);
        serve(1, 2, got);
        check_eq("hold_byte", 32'(got), 32'h3C);
        repeat (10) @(negedge clk);
        #1;
        check_eq("hold_reqs", 32'(req_cnt - base_req), 32'd1);
        check_eq("hold_level2", 32'(fifo_level), 32'd0);

        // enable low blocks new bytes but the queue still drains
        base_req = req_cnt;
        send_byte(8'h11, 1'b0, 1'b0, 1);
        send_byte(8'h22, 1'b0, 1'b0, 1);
        enable = 1'b0;
        send_byte(8'h77, 1'b0, 1'b0, 1);
        check_eq("en_level", 32'(fifo_level), 32'd1);
        serve(2, 3, got);
        check_eq("en_first", 32'(got), 32'h11);
        serve(0, 2, got);
        check_eq("en_second", 32'(got), 32'h22);
        repeat (10) @(negedge clk);
        #1;
        check_eq("en_reqs", 32'(req_cnt - base_req), 32'd2);
        check_eq("en_level0", 32'(fifo_level), 32'd0);
        enable = 1'b1;

        // Reset while waiting for tx_done with three bytes queued
        base_req = req_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 1'b0, 1'b0, 1);
        wait_req();
        tx_busy = 1'b1;
        @(negedge clk);
        check_eq("mid_level", 32'(fifo_level), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_req", 32'(send_request), 32'd0);
        check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid_rst_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("mid_reqs", 32'(req_cnt - base_req), 32'd1);
        check_eq("mid_idle_req", 32'(send_request), 32'd0);
        send_byte(8'h5A, 1'b0, 1'b0, 1);
        serve(1, 1, got);
        check_eq("mid_after", 32'(got), 32'h5A);

        // data_ready already high when reset releases counts as an edge
        reset = 1'b1;
        rx_data = 8'h99;
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rel_level", 32'(fifo_level), 32'd1);
        data_ready = 1'b0;
        serve(0, 1, got);
        check_eq("rel_byte", 32'(got), 32'h99);

        // Randomized stream against the queue model
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m_err = 0;
        got_n = 0;
        rx_done = 1'b0;
        exp_q.delete();
        base_ovf = ovf_cnt;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] b;
                    logic pe, fe, en;
                    b  = 8'($urandom);
                    pe = ($urandom_range(0, 4) == 0);
                    fe = ($urandom_range(0, 6) == 0);
                    en = ($urandom_range(0, 5) != 0);
                    if (en) begin
                        if (pe | fe) begin
                            if (m_err < 255) m_err++;
                        end else begin
                            exp_q.push_back(b);
                        end
                    end
                    enable = en;
                    send_byte(b, pe, fe, int'($urandom_range(1, 3)));
                    enable = 1'b1;
                    repeat ($urandom_range(14, 24)) @(negedge clk);
                end
                rx_done = 1'b1;
            end
            begin
                int idle = 0;
                forever begin
                    if (rx_done && got_n == exp_q.size()) break;
                    if (send_request) begin
                        serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), got);
                        if (got_n < exp_q.size())
                            check_eq("rand_byte", 32'(got), 32'(exp_q[got_n]));
                        else
                            check_eq("rand_extra", 32'(got_n), 32'(exp_q.size()));
                        got_n++;
                        idle = 0;
                    end else begin
                        @(negedge clk);
                        idle++;
                        if (idle > 500) begin
                            check_eq("rand_timeout", 32'(send_request), 32'd1);
                            break;
                        end
                    end
                end
            end
        join
        repeat (5) @(negedge clk);
        #1;
        check_eq("rand_count", 32'(got_n), 32'(exp_q.size()));
        check_eq("rand_err", 32'(err_count), 32'(m_err));
        check_eq("rand_level", 32'(fifo_level), 32'd0);
        check_eq("rand_noovf", 32'(ovf_cnt - base_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
